// File: rtl/spi_slave_if.sv
// spi_slave_if: bundles the local word-transfer handshake and the SPI pins of
// spi_slave into one interface.
//   master modport : the side driving the slave (local logic + SPI master pins)
//   slave  modport : the spi_slave block itself
// Signals:
//   cpol, cpha, nb   per-frame mode and word length (sampled at frame start)
//   tx_data, tx_load word to return in the next frame and its write strobe
//   rx_data, rx_valid last received word (right-aligned) and its 1-cycle strobe
//   busy             frame in progress
//   sclk, cs_n, mosi SPI inputs (asynchronous to clk)
//   miso             SPI output (registered)
interface spi_slave_if #(
    parameter int unsigned NBMAX = 32
);
    logic             cpol;
    logic             cpha;
    logic [7:0]       nb;
    logic [NBMAX-1:0] tx_data;
    logic             tx_load;
    logic [NBMAX-1:0] rx_data;
    logic             rx_valid;
    logic             busy;
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;

    modport master (
        output cpol, cpha, nb, tx_data, tx_load, sclk, cs_n, mosi,
        input  rx_data, rx_valid, busy, miso
    );

    modport slave (
        input  cpol, cpha, nb, tx_data, tx_load, sclk, cs_n, mosi,
        output rx_data, rx_valid, busy, miso
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI responder. Oversamples sclk/cs_n/mosi in the clk domain,
// shifts a word of 1..NBMAX bits in on mosi and out on miso (MSB first) and
// presents the received word with a one-cycle rx_valid strobe.
// Ports:
//   clk    system clock (only clock)
//   rst_n  asynchronous active-low reset
//   bus    spi_slave_if.slave: cpol, cpha, nb, tx_data, tx_load (in),
//          rx_data, rx_valid, busy (out), sclk, cs_n, mosi (in), miso (out)
// Configuration macro:
//   SPI_SLAVE_SYNC3_EN  defined -> 3-stage input synchronizers, else 2-stage.
module spi_slave #(
    parameter int unsigned NBMAX = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_slave_if.slave bus
);
`ifdef SPI_SLAVE_SYNC3_EN
    localparam int unsigned SYNC_DEPTH = 3;
`else
    localparam int unsigned SYNC_DEPTH = 2;
`endif
    localparam logic [2:0] SETTLE_CYCLES = 3'(SYNC_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    // ---------------- input synchronizers + edge-detect stage ----------------
    logic [SYNC_DEPTH-1:0] sclk_sync;
    logic [SYNC_DEPTH-1:0] cs_sync;
    logic [SYNC_DEPTH-1:0] mosi_sync;
    logic                  sclk_d;
    logic                  cs_d;
    logic [2:0]            settle;
    logic                  armed;

    // A start event is only accepted after cs_n has been seen high once the
    // synchronizers have flushed their reset values; otherwise a reset taken
    // while cs_n is held low would look like a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            settle    <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_DEPTH-2:0], bus.sclk};
            cs_sync   <= {cs_sync[SYNC_DEPTH-2:0], bus.cs_n};
            mosi_sync <= {mosi_sync[SYNC_DEPTH-2:0], bus.mosi};
            sclk_d    <= sclk_sync[SYNC_DEPTH-1];
            cs_d      <= cs_sync[SYNC_DEPTH-1];
            if (settle != SETTLE_CYCLES) begin
                settle <= settle + 3'd1;
            end
            if (settle == SETTLE_CYCLES && cs_sync[SYNC_DEPTH-1]) begin
                armed <= 1'b1;
            end
        end
    end

    // ---------------- frame state ----------------
    state_t           state;
    logic             cpol_q;
    logic             cpha_q;
    logic [7:0]       n_q;
    logic [7:0]       k;
    logic [NBMAX-1:0] tx_buf;
    logic [NBMAX-1:0] tx_sr;
    logic [NBMAX-1:0] rx_sr;
    logic             drive_en;
    logic             fin;

    // ---------------- event decode ----------------
    logic             sclk_s;
    logic             cs_s;
    logic             mosi_s;
    logic             start;
    logic             cs_rise;
    logic             lead;
    logic             trail;
    logic             sample_ev;
    logic             shift_ev;
    logic [7:0]       n_eff;
    logic [NBMAX-1:0] tx_word;

    always_comb begin
        sclk_s    = sclk_sync[SYNC_DEPTH-1];
        cs_s      = cs_sync[SYNC_DEPTH-1];
        mosi_s    = mosi_sync[SYNC_DEPTH-1];
        start     = armed && cs_d && !cs_s;
        cs_rise   = !cs_d && cs_s;
        lead      = (sclk_s != sclk_d) && (sclk_s != cpol_q);
        trail     = (sclk_s != sclk_d) && (sclk_s == cpol_q);
        sample_ev = cpha_q ? trail : lead;
        shift_ev  = cpha_q ? lead : trail;
        n_eff     = (bus.nb == 8'd0 || 32'(bus.nb) > NBMAX) ? 8'(NBMAX) : bus.nb;
        // Left-align the word so the current bit is always the MSB of tx_sr.
        tx_word   = (bus.tx_load ? bus.tx_data : tx_buf) << (NBMAX - 32'(n_eff));
    end

    assign bus.busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            n_q          <= 8'(NBMAX);
            k            <= '0;
            tx_buf       <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            drive_en     <= 1'b0;
            fin          <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bus.miso     <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            fin          <= 1'b0;
            if (bus.tx_load) begin
                tx_buf <= bus.tx_data;
            end
            // Word is published one cycle after the final sample.
            if (fin) begin
                bus.rx_valid <= 1'b1;
                bus.rx_data  <= rx_sr;
            end
            bus.miso <= (state == S_ACTIVE && drive_en) ? tx_sr[NBMAX-1] : 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ACTIVE;
                        cpol_q   <= bus.cpol;
                        cpha_q   <= bus.cpha;
                        n_q      <= n_eff;
                        k        <= '0;
                        rx_sr    <= '0;
                        tx_sr    <= tx_word;
                        // cpha=0 drives bit N-1 right away; cpha=1 waits for
                        // the first leading edge.
                        drive_en <= ~bus.cpha;
                    end
                end
                S_ACTIVE: begin
                    if (cs_rise) begin
                        state    <= S_IDLE;
                        drive_en <= 1'b0;
                    end else begin
                        if (shift_ev) begin
                            if (drive_en) begin
                                tx_sr <= tx_sr << 1;
                            end else begin
                                drive_en <= 1'b1;
                            end
                        end
                        if (sample_ev) begin
                            rx_sr <= {rx_sr[NBMAX-2:0], mosi_s};
                            if (k == n_q - 8'd1) begin
                                state    <= S_DONE;
                                drive_en <= 1'b0;
                                fin      <= 1'b1;
                            end else begin
                                k <= k + 8'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (cs_rise) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized self-checking bench for spi_slave. A behavioural
// SPI master drives the pins; expected words come from a word-level model of
// the tx buffer and of the last received word.
module tb_spi_slave;
`ifdef SPI_SLAVE_SYNC3_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 2;
`endif
    localparam int H     = DEPTH + 3;  // SCLK half period in clk cycles
    localparam int SETUP = DEPTH + 4;  // cs_n fall to first SCLK edge
    localparam int GAP   = DEPTH + 6;  // cs_n high time between frames

    logic clk;
    logic rst_n;

    spi_slave_if #(.NBMAX(32)) bus ();

    spi_slave #(.NBMAX(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcount = 0;
    int valid_cyc = 0;
    int last_edge = 0;

    logic [31:0] model_buf = '0;
    logic [31:0] model_rx  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            vcount    = vcount + 1;
            valid_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [31:0] w);
        @(negedge clk);
        bus.tx_data = w;
        bus.tx_load = 1'b1;
        wait_clk(1);
        bus.tx_load = 1'b0;
        model_buf = w;
    endtask

    // Behavioural SPI master. Returns the bits seen on miso at the sampling
    // edges and counts nonzero miso samples on clocks beyond the word.
    task automatic spi_frame(input bit pol, input bit pha, input int n,
                             input logic [31:0] wout, input int extra,
                             input int abort_at, input bit midload,
                             input logic [31:0] midword,
                             output logic [31:0] rin, output int xbad);
        rin  = '0;
        xbad = 0;
        @(negedge clk);
        bus.sclk = pol;
        wait_clk(DEPTH + 2);
        bus.cs_n = 1'b0;
        if (!pha) bus.mosi = wout[n-1];
        wait_clk(SETUP);
        for (int i = 0; i < n + extra; i++) begin
            if (abort_at >= 0 && i == abort_at) break;
            bus.sclk = ~pol;
            if (pha) begin
                bus.mosi = (i < n) ? wout[n-1-i] : 1'b0;
            end else begin
                if (i < n) rin = {rin[30:0], bus.miso};
                else if (bus.miso !== 1'b0) xbad = xbad + 1;
                if (i == n - 1) last_edge = cyc;
            end
            if (midload && i == 1) begin
                bus.tx_data = midword;
                bus.tx_load = 1'b1;
            end
            wait_clk(H);
            bus.tx_load = 1'b0;
            bus.sclk = pol;
            if (pha) begin
                if (i < n) rin = {rin[30:0], bus.miso};
                else if (bus.miso !== 1'b0) xbad = xbad + 1;
                if (i == n - 1) last_edge = cyc;
            end else begin
                bus.mosi = (i + 1 < n) ? wout[n-2-i] : 1'b0;
            end
            wait_clk(H);
        end
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        if (abort_at >= 0) begin
            wait_clk(DEPTH + 1);
            check("abort_busy", 64'(bus.busy), 64'(0));
        end
        wait_clk(GAP);
    endtask

    task automatic do_frame(input string tag, input bit pol, input bit pha,
                            input logic [7:0] nbv, input logic [31:0] mw,
                            input int extra, input int abort_at,
                            input bit midload, input logic [31:0] midword);
        int n;
        int v0;
        int xbad;
        logic [31:0] mask;
        logic [31:0] exp_tx;
        logic [31:0] got;
        n      = (nbv == 8'd0 || nbv > 8'd32) ? 32 : int'(nbv);
        mask   = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        exp_tx = model_buf & mask;
        bus.cpol = pol;
        bus.cpha = pha;
        bus.nb   = nbv;
        v0 = vcount;
        spi_frame(pol, pha, n, mw, extra, abort_at, midload, midword, got, xbad);
        if (midload) model_buf = midword;
        if (abort_at < 0) begin
            model_rx = mw & mask;
            check({tag, "_miso"}, 64'(got), 64'(exp_tx));
            check({tag, "_vcnt"}, 64'(vcount - v0), 64'(1));
            check({tag, "_vlat"}, 64'(valid_cyc - last_edge), 64'(DEPTH + 2));
        end else begin
            check({tag, "_part"}, 64'(got), 64'(exp_tx >> (n - abort_at)));
            check({tag, "_vcnt"}, 64'(vcount - v0), 64'(0));
        end
        check({tag, "_rx"}, 64'(bus.rx_data), 64'(model_rx));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        if (extra > 0) check({tag, "_xmiso"}, 64'(xbad), 64'(0));
    endtask

    initial begin
        int v0;
        rst_n       = 1'b0;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.nb      = 8'd8;
        bus.tx_data = '0;
        bus.tx_load = 1'b0;
        bus.sclk    = 1'b0;
        bus.cs_n    = 1'b1;
        bus.mosi    = 1'b0;
        wait_clk(3);
        check("rst_rx",    64'(bus.rx_data),  64'(0));
        check("rst_valid", 64'(bus.rx_valid), 64'(0));
        check("rst_busy",  64'(bus.busy),     64'(0));
        check("rst_miso",  64'(bus.miso),     64'(0));
        rst_n = 1'b1;
        wait_clk(10);

        // Mode 0, N=8
        load_tx(32'h0000_00A5);
        do_frame("m0n8", 1'b0, 1'b0, 8'd8, 32'h0000_003C, 0, -1, 1'b0, '0);

        // Mode 3, N=32
        load_tx(32'hDEAD_BEEF);
        do_frame("m3n32", 1'b1, 1'b1, 8'd32, 32'h1234_5678, 0, -1, 1'b0, '0);

        // nb out of range -> full width
        load_tx(32'h8000_0001);
        do_frame("nb0", 1'b0, 1'b1, 8'd0, 32'hC001_D00D, 0, -1, 1'b0, '0);
        load_tx(32'h7654_3210);
        do_frame("nb40", 1'b1, 1'b0, 8'd40, 32'h0F0F_A5A5, 0, -1, 1'b0, '0);

        // abort after 5 of 8 bits
        load_tx(32'h0000_00C3);
        do_frame("abort", 1'b0, 1'b0, 8'd8, 32'h0000_0099, 0, 5, 1'b0, '0);

        // extra SCLKs after N=16 plus mid-frame tx_load, then next frame
        load_tx(32'h0000_BEEF);
        do_frame("extra", 1'b0, 1'b1, 8'd16, 32'h0000_1357, 4, -1, 1'b1, 32'h0000_4321);
        do_frame("nextw", 1'b1, 1'b0, 8'd16, 32'h0000_2468, 4, -1, 1'b0, '0);

        // reset mid-frame
        load_tx(32'h0000_00F0);
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        bus.nb   = 8'd8;
        @(negedge clk);
        bus.cs_n = 1'b0;
        wait_clk(SETUP);
        for (int i = 0; i < 3; i++) begin
            bus.sclk = 1'b1;
            wait_clk(H);
            bus.sclk = 1'b0;
            wait_clk(H);
        end
        rst_n = 1'b0;
        #1;
        check("mrst_rx",    64'(bus.rx_data),  64'(0));
        check("mrst_valid", 64'(bus.rx_valid), 64'(0));
        check("mrst_busy",  64'(bus.busy),     64'(0));
        check("mrst_miso",  64'(bus.miso),     64'(0));
        model_buf = '0;
        model_rx  = '0;
        wait_clk(2);
        rst_n = 1'b1;
        v0 = vcount;
        for (int i = 0; i < 5; i++) begin
            bus.sclk = 1'b1;
            wait_clk(H);
            bus.sclk = 1'b0;
            wait_clk(H);
        end
        check("norsm_busy", 64'(bus.busy), 64'(0));
        check("norsm_vcnt", 64'(vcount - v0), 64'(0));
        bus.cs_n = 1'b1;
        wait_clk(GAP);
        load_tx(32'h0000_005A);
        do_frame("postrst", 1'b0, 1'b0, 8'd8, 32'h0000_00E7, 0, -1, 1'b0, '0);

        // randomized frames
        for (int t = 0; t < 14; t++) begin
            bit pol;
            bit pha;
            logic [7:0] nbv;
            int n;
            int ab;
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            nbv = 8'($urandom_range(0, 40));
            n   = (nbv == 8'd0 || nbv > 8'd32) ? 32 : int'(nbv);
            ab  = -1;
            if ($urandom_range(0, 3) == 0 && n > 1) ab = $urandom_range(1, n - 1);
            if ($urandom_range(0, 1) == 1) load_tx($urandom);
            do_frame($sformatf("rnd%0d", t), pol, pha, nbv, $urandom,
                     int'($urandom_range(0, 2)), ab, 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
